uart_status_reporter: RTL and testbench

- Transmit-side counterpart of the glitcher's UART command path.
- Serializes a snapshot of the current glitch configuration, as a framed, checksummed status packet, on a read-back request.
- Emits a one-byte completion notification when a glitch sequence finishes.
- Sits between the configuration registers / glitch sequencer and the `uart_tx` instance, driving its byte-enable handshake.

---
 rtl/uart_status_reporter_if.sv | 28 ++
 rtl/uart_status_reporter.sv | 185 ++++++++++++++++++
 tb/tb_uart_status_reporter.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_status_reporter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_status_reporter_if
// Description : Byte-enable handshake between the status reporter and the
//               uart_tx instance.
//               master (reporter) : drives tx_data_o / tx_enable_o,
//                                   observes tx_busy_i
//               slave  (uart_tx)  : observes data/enable, drives tx_busy_i
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_status_reporter_if;
    logic [7:0] tx_data_o;     // byte to transmit
    logic       tx_enable_o;   // one-cycle transmit strobe
    logic       tx_busy_i;     // transmitter busy flag

    modport master (
        output tx_data_o,
        output tx_enable_o,
        input  tx_busy_i
    );

    modport slave (
        input  tx_data_o,
        input  tx_enable_o,
        output tx_busy_i
    );
endinterface
`default_nettype wire

// File: rtl/uart_status_reporter.sv
`default_nettype none
// ============================================================================
// Module      : uart_status_reporter
// Description : Transmit side of the glitcher UART path. On a read-back
//               request it sends an 11-byte status packet:
//                 'S', delay hi/lo, width, num_pulses, spacing hi/lo,
//                 reset_len hi/lo, {7'b0,armed}, XOR of bytes 1..9.
//               On sequence completion it sends the single byte 'D'.
//               Requests are latched in pending flags so pulses arriving
//               during a transfer coalesce into one follow-up message.
// Ports       : clk, rst_n (sync, active-low)
//               report_req_i, done_i   - request pulses
//               armed_i, delay_i, width_i, num_pulses_i, pulse_spacing_i,
//               reset_length_i         - live configuration
//               tx_if (master)         - uart_tx byte handshake
//               busy_o                 - high whenever not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_status_reporter (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  report_req_i,
    input  wire logic                  done_i,
    input  wire logic                  armed_i,
    input  wire logic [15:0]           delay_i,
    input  wire logic [7:0]            width_i,
    input  wire logic [7:0]            num_pulses_i,
    input  wire logic [15:0]           pulse_spacing_i,
    input  wire logic [15:0]           reset_length_i,
    uart_status_reporter_if.master     tx_if,
    output      logic                  busy_o
);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_LOAD      = 3'd1;
    localparam logic [2:0] c_ST_SEND      = 3'd2;
    localparam logic [2:0] c_ST_WAIT_ACK  = 3'd3;
    localparam logic [2:0] c_ST_WAIT_DONE = 3'd4;

    localparam logic [7:0] c_HEADER_BYTE  = 8'h53;   // 'S'
    localparam logic [7:0] c_DONE_BYTE    = 8'h44;   // 'D'
    localparam logic [3:0] c_STATUS_LAST  = 4'd10;   // index of checksum byte

    logic [2:0]  r_state;
    logic        r_mode_status;     // 1: status packet, 0: done notification
    logic [3:0]  r_idx;
    logic        r_report_pending;
    logic        r_done_pending;

    // Snapshot of the configuration taken in LOAD
    logic [15:0] r_delay;
    logic [7:0]  r_width;
    logic [7:0]  r_num_pulses;
    logic [15:0] r_spacing;
    logic [15:0] r_reset_len;
    logic        r_armed;
    logic [7:0]  r_checksum;

    logic [7:0]  r_tx_data;
    logic        r_tx_enable;

    logic        w_start_status;
    logic        w_start_done;
    logic        w_last_byte;
    logic [7:0]  w_checksum;
    logic [7:0]  w_pkt_byte;

    // Status wins when both flags are pending
    assign w_start_status = (r_state == c_ST_IDLE) && r_report_pending;
    assign w_start_done   = (r_state == c_ST_IDLE) && !r_report_pending && r_done_pending;

    // The done notification is one byte long, so its only index is also its last
    assign w_last_byte = r_mode_status ? (r_idx == c_STATUS_LAST) : 1'b1;

    // Checksum over the live inputs; captured together with the snapshot
    assign w_checksum = delay_i[15:8] ^ delay_i[7:0] ^ width_i ^ num_pulses_i
                      ^ pulse_spacing_i[15:8] ^ pulse_spacing_i[7:0]
                      ^ reset_length_i[15:8] ^ reset_length_i[7:0]
                      ^ {7'b0, armed_i};

    always_comb begin
        w_pkt_byte = 8'h00;
        if (!r_mode_status) begin
            w_pkt_byte = c_DONE_BYTE;
        end else begin
            case (r_idx)
                4'd0:    w_pkt_byte = c_HEADER_BYTE;
                4'd1:    w_pkt_byte = r_delay[15:8];
                4'd2:    w_pkt_byte = r_delay[7:0];
                4'd3:    w_pkt_byte = r_width;
                4'd4:    w_pkt_byte = r_num_pulses;
                4'd5:    w_pkt_byte = r_spacing[15:8];
                4'd6:    w_pkt_byte = r_spacing[7:0];
                4'd7:    w_pkt_byte = r_reset_len[15:8];
                4'd8:    w_pkt_byte = r_reset_len[7:0];
                4'd9:    w_pkt_byte = {7'b0, r_armed};
                4'd10:   w_pkt_byte = r_checksum;
                default: w_pkt_byte = 8'h00;
            endcase
        end
    end

    // Pending flags: a pulse in the same cycle as the clear keeps the flag set
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_report_pending <= 1'b0;
            r_done_pending   <= 1'b0;
        end else begin
            r_report_pending <= report_req_i | (r_report_pending & ~w_start_status);
            r_done_pending   <= done_i       | (r_done_pending   & ~w_start_done);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_ST_IDLE;
            r_mode_status <= 1'b0;
            r_idx         <= 4'd0;
            r_delay       <= 16'h0000;
            r_width       <= 8'h00;
            r_num_pulses  <= 8'h00;
            r_spacing     <= 16'h0000;
            r_reset_len   <= 16'h0000;
            r_armed       <= 1'b0;
            r_checksum    <= 8'h00;
            r_tx_data     <= 8'h00;
            r_tx_enable   <= 1'b0;
        end else begin
            r_tx_enable <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start_status) begin
                        r_mode_status <= 1'b1;
                        r_state       <= c_ST_LOAD;
                    end else if (w_start_done) begin
                        r_mode_status <= 1'b0;
                        r_state       <= c_ST_LOAD;
                    end
                end
                c_ST_LOAD: begin
                    if (r_mode_status) begin
                        r_delay      <= delay_i;
                        r_width      <= width_i;
                        r_num_pulses <= num_pulses_i;
                        r_spacing    <= pulse_spacing_i;
                        r_reset_len  <= reset_length_i;
                        r_armed      <= armed_i;
                        r_checksum   <= w_checksum;
                    end
                    r_idx   <= 4'd0;
                    r_state <= c_ST_SEND;
                end
                c_ST_SEND: begin
                    if (!tx_if.tx_busy_i) begin
                        r_tx_enable <= 1'b1;
                        r_tx_data   <= w_pkt_byte;
                        r_state     <= c_ST_WAIT_ACK;
                    end
                end
                c_ST_WAIT_ACK: begin
                    if (tx_if.tx_busy_i) begin
                        r_state <= c_ST_WAIT_DONE;
                    end
                end
                c_ST_WAIT_DONE: begin
                    if (!tx_if.tx_busy_i) begin
                        if (w_last_byte) begin
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_state <= c_ST_SEND;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign tx_if.tx_data_o   = r_tx_data;
    assign tx_if.tx_enable_o = r_tx_enable;
    assign busy_o            = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_status_reporter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_status_reporter
// Description : Self-checking bench for uart_status_reporter. A behavioural
//               uart_tx model answers the byte handshake; a monitor records
//               every transmitted byte. Expected byte streams come from a
//               table of hand-computed packets and from a packet-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_status_reporter;

    typedef struct {
        logic [15:0] delay;
        logic [7:0]  width;
        logic [7:0]  num;
        logic [15:0] spacing;
        logic [15:0] rlen;
        logic        armed;
        logic [7:0]  chk;      // expected checksum byte
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        report_req = 1'b0;
    logic        done = 1'b0;
    logic        armed = 1'b0;
    logic [15:0] delay = 16'h0;
    logic [7:0]  width = 8'h0;
    logic [7:0]  num = 8'h0;
    logic [15:0] spacing = 16'h0;
    logic [15:0] rlen = 16'h0;
    logic        busy;

    int checks = 0;
    int failures = 0;

    logic [7:0] cap_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_status_reporter_if bus ();

    uart_status_reporter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .report_req_i    (report_req),
        .done_i          (done),
        .armed_i         (armed),
        .delay_i         (delay),
        .width_i         (width),
        .num_pulses_i    (num),
        .pulse_spacing_i (spacing),
        .reset_length_i  (rlen),
        .tx_if           (bus),
        .busy_o          (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- uart_tx model ----------------
    int  ack_delay = 0;     // cycles after the enable before busy rises
    int  hold = 3;          // extra busy cycles
    bit  force_hi = 1'b0;
    bit  force_lo = 1'b0;
    logic m_busy = 1'b0;
    bit  m_pend = 1'b0;
    int  dcnt = 0;
    int  hcnt = 0;

    always @(posedge clk) begin
        if (bus.tx_enable_o) begin
            if (ack_delay == 0) begin
                m_busy <= 1'b1;
                hcnt   <= hold;
            end else begin
                m_pend <= 1'b1;
                dcnt   <= ack_delay - 1;
            end
        end else if (m_pend) begin
            if (dcnt == 0) begin
                m_pend <= 1'b0;
                m_busy <= 1'b1;
                hcnt   <= hold;
            end else begin
                dcnt <= dcnt - 1;
            end
        end else if (m_busy) begin
            if (hcnt == 0) m_busy <= 1'b0;
            else           hcnt   <= hcnt - 1;
        end
    end

    assign bus.tx_busy_i = force_hi | (!force_lo & m_busy);

    // ---------------- monitor ----------------
    logic       rst_applied = 1'b0;
    logic       prev_en = 1'b0;
    logic [7:0] last_data = 8'h00;

    always @(posedge clk) rst_applied <= !rst_n;

    always @(negedge clk) begin
        if (rst_applied) begin
            last_data = 8'h00;
        end else if (bus.tx_enable_o) begin
            if (prev_en) check("strobe_back_to_back", 32'd1, 32'd0);
            cap_q.push_back(bus.tx_data_o);
            last_data = bus.tx_data_o;
        end else begin
            check("data_stable", {24'h0, bus.tx_data_o}, {24'h0, last_data});
        end
        prev_en = bus.tx_enable_o;
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_report();
        report_req = 1'b1;
        tick(1);
        report_req = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick(1);
        done = 1'b0;
    endtask

    task automatic apply_cfg(input vec_t v);
        delay = v.delay; width = v.width; num = v.num;
        spacing = v.spacing; rlen = v.rlen; armed = v.armed;
    endtask

    task automatic clear_q();
        cap_q.delete();
        exp_q.delete();
    endtask

    // Idle means busy_o low for several cycles in a row, which rules out the
    // one-cycle idle gap between two queued messages.
    task automatic wait_idle(input string name, input int max_cycles);
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < max_cycles) begin
            @(negedge clk);
            n++;
            if (busy) quiet = 0;
            else      quiet++;
        end
        check({name, "_idle_timeout"}, (quiet >= 4) ? 32'd1 : 32'd0, 32'd1);
        tick(1);
    endtask

    task automatic wait_bytes(input string name, input int count, input int max_cycles);
        int n = 0;
        while (cap_q.size() < count && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check({name, "_byte_timeout"}, (cap_q.size() >= count) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Packet-level model: header, payload fields, XOR of the payload
    task automatic model_status(input vec_t v);
        logic [7:0] payload[9];
        logic [7:0] x;
        payload = '{v.delay[15:8], v.delay[7:0], v.width, v.num,
                    v.spacing[15:8], v.spacing[7:0], v.rlen[15:8], v.rlen[7:0],
                    {7'b0, v.armed}};
        x = 8'h00;
        exp_q.push_back(8'h53);
        foreach (payload[i]) begin
            exp_q.push_back(payload[i]);
            x = x ^ payload[i];
        end
        exp_q.push_back(x);
    endtask

    task automatic compare_q(input string name);
        check({name, "_count"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            check($sformatf("%s_byte%0d", name, i), {24'h0, cap_q[i]}, {24'h0, exp_q[i]});
    endtask

    function automatic vec_t rand_cfg();
        vec_t v;
        v.delay   = 16'($urandom);
        v.width   = 8'($urandom);
        v.num     = 8'($urandom);
        v.spacing = 16'($urandom);
        v.rlen    = 16'($urandom);
        v.armed   = 1'($urandom);
        v.chk     = 8'h00;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    vec_t tbl[4];
    vec_t va;
    vec_t vb;

    initial begin
        // Hand-computed packets (checksum = XOR of bytes 1..9)
        tbl[0] = '{16'h1234, 8'h05, 8'h03, 16'h00A0, 16'h0000, 1'b1, 8'h81};
        tbl[1] = '{16'hFFFF, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF, 1'b0, 8'h00};
        tbl[2] = '{16'h0000, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b1, 8'h01};
        tbl[3] = '{16'hBEEF, 8'h10, 8'h20, 16'h0102, 16'h8040, 1'b0, 8'hA2};

        // ---- reset state ----
        tick(2);
        check("reset_enable", {31'h0, bus.tx_enable_o}, 32'd0);
        check("reset_data",   {24'h0, bus.tx_data_o},   32'd0);
        check("reset_busy",   {31'h0, busy},            32'd0);
        rst_n = 1'b1;
        tick(3);

        // ---- table: status packets, busy rises 1 cycle after enable ----
        ack_delay = 0;
        hold = 3;
        for (int i = 0; i < 4; i++) begin
            apply_cfg(tbl[i]);
            clear_q();
            pulse_report();
            tick(2);
            check($sformatf("tbl%0d_latency_pre", i), {31'h0, bus.tx_enable_o}, 32'd0);
            tick(1);
            check($sformatf("tbl%0d_latency", i), {31'h0, bus.tx_enable_o}, 32'd1);
            wait_idle($sformatf("tbl%0d", i), 500);
            exp_q = '{8'h53, tbl[i].delay[15:8], tbl[i].delay[7:0], tbl[i].width, tbl[i].num,
                      tbl[i].spacing[15:8], tbl[i].spacing[7:0], tbl[i].rlen[15:8],
                      tbl[i].rlen[7:0], {7'b0, tbl[i].armed}, tbl[i].chk};
            compare_q($sformatf("tbl%0d", i));
        end

        // ---- done notification while transmitter is busy ----
        clear_q();
        force_hi = 1'b1;
        pulse_done();
        tick(50);
        check("done_held_strobes", cap_q.size(), 32'd0);
        force_hi = 1'b0;
        wait_idle("done", 200);
        exp_q.push_back(8'h44);
        compare_q("done");
        check("done_busy_low", {31'h0, busy}, 32'd0);

        // ---- simultaneous report and done ----
        apply_cfg(tbl[3]);
        clear_q();
        report_req = 1'b1;
        done = 1'b1;
        tick(1);
        report_req = 1'b0;
        done = 1'b0;
        wait_idle("both", 1000);
        model_status(tbl[3]);
        exp_q.push_back(8'h44);
        compare_q("both");

        // ---- coalesced requests and config change in flight ----
        va = tbl[0];
        va.delay = 16'h1111;
        vb = va;
        vb.delay = 16'hBEEF;
        apply_cfg(va);
        clear_q();
        pulse_report();
        wait_bytes("coalesce", 3, 200);
        tick(1);
        for (int i = 0; i < 3; i++) begin
            pulse_report();
            tick(1);
        end
        delay = 16'hBEEF;
        wait_idle("coalesce", 2000);
        model_status(va);
        model_status(vb);
        compare_q("coalesce");

        // ---- reset mid-packet ----
        apply_cfg(tbl[0]);
        clear_q();
        pulse_report();
        wait_bytes("midreset", 4, 300);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        tick(1);
        check("midreset_enable", {31'h0, bus.tx_enable_o}, 32'd0);
        check("midreset_busy",   {31'h0, busy},            32'd0);
        check("midreset_data",   {24'h0, bus.tx_data_o},   32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(60);
        check("midreset_no_more", cap_q.size(), 32'd4);
        clear_q();
        pulse_report();
        wait_idle("after_reset", 500);
        model_status(tbl[0]);
        compare_q("after_reset");

        // ---- broken transmitter: busy never rises ----
        clear_q();
        force_lo = 1'b1;
        pulse_report();
        tick(60);
        check("broken_strobes", cap_q.size(), 32'd1);
        check("broken_busy",    {31'h0, busy}, 32'd1);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        force_lo = 1'b0;
        tick(20);

        // ---- randomized traffic against the packet model ----
        for (int it = 0; it < 25; it++) begin
            int pat;
            va = rand_cfg();
            apply_cfg(va);
            ack_delay = $urandom_range(0, 3);
            hold      = $urandom_range(0, 8);
            pat       = $urandom_range(0, 3);
            clear_q();
            case (pat)
                0: begin
                    pulse_report();
                    model_status(va);
                end
                1: begin
                    pulse_done();
                    exp_q.push_back(8'h44);
                end
                2: begin
                    report_req = 1'b1;
                    done = 1'b1;
                    tick(1);
                    report_req = 1'b0;
                    done = 1'b0;
                    model_status(va);
                    exp_q.push_back(8'h44);
                end
                default: begin
                    pulse_report();
                    tick($urandom_range(1, 20));
                    pulse_done();
                    model_status(va);
                    exp_q.push_back(8'h44);
                end
            endcase
            wait_idle($sformatf("rand%0d", it), 2000);
            compare_q($sformatf("rand%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
